// File: rtl/occupancy_counter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | occ_pkg: shared event encoding and clamp helper for the counter.  |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
package occ_pkg;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_INC  = 2'd1,
      EV_DEC  = 2'd2,
      EV_BOTH = 2'd3
   } occ_ev_t;

   function automatic int unsigned clamp_to_max(input int unsigned value,
                                                input int unsigned max_val);
      return (value > max_val) ? max_val : value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/occupancy_counter_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | occupancy_counter_if: request/status bundle of the counter.       |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
interface occupancy_counter_if #(
   parameter int WIDTH = 5
);
   logic             incr;
   logic             decr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_err;
   logic [WIDTH-1:0] out;
   logic             full;
   logic             empty;
   logic             ovf_err;
   logic             unf_err;
   logic             changed;

   modport master (
      output incr, decr, load, load_val, clr_err,
      input  out, full, empty, ovf_err, unf_err, changed
   );

   modport slave (
      input  incr, decr, load, load_val, clr_err,
      output out, full, empty, ovf_err, unf_err, changed
   );
endinterface
`default_nettype wire

// File: rtl/occupancy_counter_edge_detect.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | edge_detect: rising-edge or pass-through level event generator.   |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module edge_detect #(
   parameter int EDGE_MODE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic ev_o
);
   localparam logic EDGE_BIT = (EDGE_MODE != 0);

   logic sig_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   // In level mode the history term is masked out and the input passes straight through.
   assign ev_o = sig_i & ~(sig_q & EDGE_BIT);

endmodule
`default_nettype wire

// File: rtl/occupancy_counter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | occupancy_counter: saturating up/down count with sticky errors.   |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module occupancy_counter #(
   parameter int WIDTH     = 5,
   parameter int MAX       = 16,
   parameter int EDGE_MODE = 1
) (
   input  logic                clk,
   input  logic                reset,
   occupancy_counter_if.slave  occ
);
   import occ_pkg::*;

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

   generate
      if (MAX < 1 || MAX > (2**WIDTH) - 1) begin : g_bad_max
         $error("occupancy_counter: MAX must lie in 1 .. 2**WIDTH-1");
      end
   endgenerate

   logic             inc_ev;
   logic             dec_ev;
   occ_ev_t          ev;
   logic [WIDTH-1:0] out_q,     out_d;
   logic             ovf_q,     ovf_d;
   logic             unf_q,     unf_d;
   logic             stepped_q, stepped_d;
   logic             changed_q;

   edge_detect #(.EDGE_MODE(EDGE_MODE)) u_incr_edge (
      .clk   (clk),
      .reset (reset),
      .sig_i (occ.incr),
      .ev_o  (inc_ev)
   );

   edge_detect #(.EDGE_MODE(EDGE_MODE)) u_decr_edge (
      .clk   (clk),
      .reset (reset),
      .sig_i (occ.decr),
      .ev_o  (dec_ev)
   );

   assign ev = occ_ev_t'({dec_ev, inc_ev});

   always_comb begin
      out_d = out_q;
      ovf_d = ovf_q & ~occ.clr_err;
      unf_d = unf_q & ~occ.clr_err;
      if (occ.load) begin
         out_d = WIDTH'(clamp_to_max(32'(occ.load_val), 32'(MAX)));
      end else begin
         case (ev)
            EV_INC: begin
               if (out_q == MAX_VAL) begin
                  ovf_d = 1'b1;
               end else begin
                  out_d = out_q + WIDTH'(1);
               end
            end
            EV_DEC: begin
               if (out_q == '0) begin
                  unf_d = 1'b1;
               end else begin
                  out_d = out_q - WIDTH'(1);
               end
            end
            default: out_d = out_q;
         endcase
      end
      // changed trails the count update by one further cycle, hence the two-stage pipe.
      stepped_d = (out_d != out_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         stepped_q <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         stepped_q <= stepped_d;
         changed_q <= stepped_q;
      end
   end

   assign occ.out     = out_q;
   assign occ.full    = (out_q == MAX_VAL);
   assign occ.empty   = (out_q == '0);
   assign occ.ovf_err = ovf_q;
   assign occ.unf_err = unf_q;
   assign occ.changed = changed_q;

endmodule
`default_nettype wire
